// File: rtl/neuron_mac_seq.sv
// Serial neuron: one signed-weight x unsigned-input product per clock, then ReLU, shift and clip.
// Result valid N_IN+1 edges after acceptance; OUT holds y/sat until out_ready, and no input is taken meanwhile.
module neuron_mac_seq #(
  parameter int N_IN  = 4,
  parameter int XW    = 8,
  parameter int WW    = 8,
  parameter int ACCW  = 20,
  parameter int SHIFT = 2,
  parameter int YW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*XW-1:0]   x_flat,
  input  logic [N_IN*WW-1:0]   w_flat,
  input  logic [WW-1:0]        b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [YW-1:0]        y,
  output logic                 sat
);

  localparam int IDXW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW   = WW + XW + 1;
  localparam logic [ACCW-1:0] YMAX = {{(ACCW-YW){1'b0}}, {YW{1'b1}}};

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  state_t                 state, state_nxt;
  logic [IDXW-1:0]        idx;
  logic signed [ACCW-1:0] acc;
  logic [N_IN*XW-1:0]     x_q;
  logic [N_IN*WW-1:0]     w_q;

  logic [XW-1:0]          x_sel;
  logic [WW-1:0]          w_sel;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] t;
  logic [YW-1:0]          y_nxt;
  logic                   sat_nxt;
  logic                   last;

  assign in_ready = (state == IDLE) && rst_n;
  assign last     = (idx == IDXW'(N_IN - 1));

  assign x_sel = x_q[idx*XW +: XW];
  assign w_sel = w_q[idx*WW +: WW];
  // x is zero-extended by one bit so the multiply stays fully signed
  assign prod  = $signed(w_sel) * $signed({1'b0, x_sel});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (last)     state_nxt = ACT;
      ACT:                   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Arithmetic shift floors toward -inf, so small negative sums land at -1 and clamp to 0
  always_comb begin
    t       = acc >>> SHIFT;
    y_nxt   = '0;
    sat_nxt = 1'b0;
    if (t[ACCW-1]) begin
      y_nxt   = '0;
      sat_nxt = 1'b0;
    end else if ($unsigned(t) > YMAX) begin
      y_nxt   = '1;
      sat_nxt = 1'b1;
    end else begin
      y_nxt   = t[YW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      acc       <= '0;
      x_q       <= '0;
      w_q       <= '0;
      y         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q <= x_flat;
            w_q <= w_flat;
            acc <= {{(ACCW-WW){b[WW-1]}}, b};
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACCW-PW){prod[PW-1]}}, prod};
          idx <= last ? '0 : idx + 1'b1;
        end
        ACT: begin
          y         <= y_nxt;
          sat       <= sat_nxt;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Parametrised, time-multiplexed successor to the 4-input pipelined neuron.
- Computes y = clip(max(0, (b + Σ w[i]·x[i]) >>> SHIFT), 0, 2^YW−1) over N_IN inputs.
- Uses one shared multiply-accumulate datapath, one product per clock.
- Has a valid/ready handshake on both sides, so it can chain into layers and absorb back-pressure.

Parameters:
N_IN, 4, number of input/weight pairs (≥1)
XW, 8, input width (unsigned)
WW, 8, weight and bias width (signed two's complement)
ACCW, 20, accumulator width (signed); must be ≥ XW+WW+clog2(N_IN+1)
SHIFT, 2, arithmetic right shift applied before activation
YW, 8, output width (unsigned)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  x_flat, w_flat and b hold a valid input set
in_ready  out  1  block can accept an input set
x_flat  in  N_IN*XW  inputs; x[i] = x_flat[i*XW +: XW], unsigned
w_flat  in  N_IN*WW  weights; w[i] = w_flat[i*WW +: WW], signed
b  in  WW  bias, signed
out_valid  out  1  y and sat are valid
out_ready  in  1  downstream accepts y
y  out  YW  activated output, unsigned
sat  out  1  y was clipped at 2^YW−1

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is synchronous, active-low (rst_n sampled on the rising edge).
  - On reset: state=IDLE, idx=0, acc=0, captured registers=0, y=0, sat=0, out_valid=0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after reset release.
  - Reset asserted in any state, including mid-MAC or OUT, aborts the operation; the partial result is discarded.
- FSM states: IDLE, MAC, ACT, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
    - capture x, w, b;
    - acc ← sign-extend(b) to ACCW;
    - idx ← 0; go to MAC.
  - MAC: each edge does acc ← acc + signed(w[idx])·zero-extend(x[idx]) and idx ← idx+1. On idx=N_IN−1, go to ACT. This takes exactly N_IN edges (E1..E_N_IN).
  - ACT (one edge, E_N_IN+1):
    - t = acc >>> SHIFT (floor toward −∞);
    - if t<0: y=0, sat=0;
    - else if t>2^YW−1: y=2^YW−1, sat=1;
    - else: y=t[YW−1:0], sat=0;
    - out_valid ← 1; go to OUT.
  - OUT: y, sat and out_valid are held stable. On out_ready=1 at an edge: out_valid ← 0; go to IDLE.
- Handshake rules:
  - in_ready = (state==IDLE) && rst_n. in_valid outside IDLE is ignored and no data is captured.
  - Input operands are registered at acceptance; the source may change x_flat, w_flat and b freely afterwards.
  - y and sat change only on the ACT edge or on reset.
  - out_ready arriving while out_valid=0 has no effect.
- Latency: out_valid is first seen high in the cycle after edge E0+N_IN+1.
- Throughput: minimum spacing between acceptances is N_IN+3 cycles when out_ready is tied high (the N_IN+2 edges from E0 through the OUT-to-IDLE edge, plus one edge in IDLE).
- Arithmetic and overflow:
  - Products are WW+XW+1 bits signed.
  - With ACCW obeying the width rule above, no accumulator overflow is possible; behaviour for an undersized ACCW is undefined.
  - Zero product terms and zero bias are legal.
- The single-product-per-cycle serial datapath is the intended area trade against the parallel neuron; no multiplier is replicated.

Test Plan:
- Defaults; x=10,20,30,40; w=1,2,3,4; b=0; accept at E0 → acc=300; y=75, sat=0; out_valid high after E5; in_ready=0 during E1..E5.
- x=100×4, w=−1×4, b=5 → acc=−395 → y=0, sat=0. Separately, acc=3 (x0=3, w0=1, rest 0, b=0) → y=0 (floor shift).
- x=255×4, w=127×4, b=127 → acc=129667, t=32416 → y=255, sat=1.
- Back-pressure: after out_valid, hold out_ready=0 for 10 cycles while toggling in_valid and random x/w/b → y stable, in_ready=0, nothing captured. Then out_ready=1 → IDLE next cycle, in_ready=1; a new set is accepted and computed correctly.
- Reset: drop rst_n for one cycle at E2 (mid-MAC) → next cycle state=IDLE, y=0, out_valid=0. A following set (the first test vector) yields y=75 with no residue from the aborted set.
- Back-to-back with N_IN=8, XW=4, WW=6, ACCW=14, SHIFT=0, YW=8 and out_ready tied 1: two sets accepted 11 cycles apart; x=15×8, w=31×8, b=−31 → t=3689 → y=255, sat=1. Second set with all w=0 and b=7 → y=7.
